fetch_stage: RTL and testbench

Instruction fetch stage for the 16-bit single-issue core. It owns the architectural PC and issues one-outstanding-request reads to instruction memory through a req/rdy handshake. It buffers one fetched instruction in an output slot that decode drains under a stall handshake. It also supplies pc_out/pc_plus2, which decode and the register-file stage use for link (JAL/JALR R7) writes. Redirects (branch/jump resolution) and HALT detection are handled here.

---
 rtl/fetch_stage.sv | 150 +++++++++++++++
 tb/tb_fetch_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the architectural PC, issues single
// outstanding reads to instruction memory and buffers one fetched
// instruction in an output slot drained by decode.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [4:0]  HALT_OPC = 5'b00000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] instr,
  output logic [15:0] pc_out,
  output logic [15:0] pc_plus2,
  output logic        valid,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_DROP  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  // Address of a request whose response will be thrown away; the PC
  // already holds the redirect target while this request completes.
  logic [15:0] drop_addr_q, drop_addr_d;

  logic        req_c;
  logic [15:0] addr_c;
  logic        load_c;
  logic        slot_free_c;

  // State register and architectural registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      instr_q     <= 16'h0000;
      pc_out_q    <= 16'h0000;
      valid_q     <= 1'b0;
      drop_addr_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pc_out_q    <= pc_out_d;
      valid_q     <= valid_d;
      drop_addr_q <= drop_addr_d;
    end
  end

  // Next-state, slot update and memory request generation.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    pc_out_d    = pc_out_q;
    valid_d     = valid_q;
    drop_addr_d = drop_addr_q;
    load_c      = 1'b0;
    req_c       = 1'b0;
    addr_c      = pc_q;

    slot_free_c = !valid_q || !stall;

    // A drained slot empties unless refilled below.
    if (valid_q && !stall) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_FETCH: begin
        req_c = slot_free_c;
        if (req_c) begin
          if (imem_rdy) begin
            load_c = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        req_c = 1'b1;
        if (imem_rdy) begin
          load_c = 1'b1;
        end
      end
      S_DROP: begin
        req_c  = 1'b1;
        addr_c = drop_addr_q;
        if (imem_rdy) begin
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        req_c = 1'b0;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    if (load_c) begin
      instr_d  = imem_data;
      pc_out_d = pc_q;
      valid_d  = 1'b1;
      pc_d     = pc_q + 16'd2;
      state_d  = (imem_data[15:11] == HALT_OPC) ? S_HALT : S_FETCH;
    end

    // Redirect overrides everything: flush the slot and retarget the PC.
    // Any request still unacknowledged must complete at its old address,
    // so it is tracked in DROP and its data discarded.
    if (redirect) begin
      pc_d     = redirect_pc & 16'hFFFE;
      valid_d  = 1'b0;
      instr_d  = instr_q;
      pc_out_d = pc_out_q;
      if (req_c && !imem_rdy) begin
        state_d = S_DROP;
        if (state_q != S_DROP) begin
          drop_addr_d = pc_q;
        end
      end else begin
        state_d = S_FETCH;
      end
    end
  end

  assign imem_req  = req_c;
  assign imem_addr = addr_c;
  assign instr     = instr_q;
  assign pc_out    = pc_out_q;
  assign pc_plus2  = pc_out_q + 16'd2;
  assign valid     = valid_q;
  assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a memory responder with configurable latency and
// a request-level reference model of the fetch behaviour.
module tb_fetch_stage;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [4:0]  HALT_OPC = 5'b00000;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy;
  logic [15:0] imem_data;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] instr;
  logic [15:0] pc_out;
  logic [15:0] pc_plus2;
  logic        valid;
  logic        halted;

  fetch_stage #(.RESET_PC(RESET_PC), .HALT_OPC(HALT_OPC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdy(imem_rdy), .imem_data(imem_data),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr(instr), .pc_out(pc_out), .pc_plus2(pc_plus2),
    .valid(valid), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: PC, output slot, halt flag and the single
  // in-flight memory request (with a "discard" mark after redirect).
  logic [15:0] m_pc;
  logic        m_valid;
  logic [15:0] m_instr;
  logic [15:0] m_spc;
  logic        m_halted;
  logic        m_out;
  logic [15:0] m_oaddr;
  logic        m_disc;
  int          m_wcnt;
  int          m_lat;
  int          lat_fix;
  logic [15:0] halt_addr;

  function automatic logic [15:0] memword(input logic [15:0] a);
    logic [15:0] w;
    if (a == halt_addr) begin
      w = {5'b00000, a[10:0]};
    end else begin
      w = 16'h1000 + a;
      if (w[15:11] == 5'b00000) w[15] = 1'b1;
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc     = RESET_PC;
    m_valid  = 1'b0;
    m_instr  = 16'h0000;
    m_spc    = 16'h0000;
    m_halted = 1'b0;
    m_out    = 1'b0;
    m_oaddr  = 16'h0000;
    m_disc   = 1'b0;
    m_wcnt   = 0;
    m_lat    = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    imem_rdy = 1'b0; imem_data = 16'h0000;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    $display("reset: valid=%0b halted=%0b instr=%h pc_out=%h", valid, halted, instr, pc_out);
    chk("rst_valid", {15'd0, valid}, 16'd0);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_pc_out", pc_out, 16'h0000);
  endtask

  // One clock cycle: drive inputs, answer memory, check, advance model.
  task automatic cycle(input logic s, input logic r, input logic [15:0] rp);
    logic        free, e_req, e_rdy;
    logic [15:0] e_addr, d;
    stall = s; redirect = r; redirect_pc = rp;
    free   = !m_valid || !s;
    e_req  = !m_halted && (m_out || free);
    e_addr = m_out ? m_oaddr : m_pc;
    if (e_req && !m_out) begin
      m_wcnt = 0;
      m_lat  = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
    end
    e_rdy = e_req && (m_wcnt == m_lat);
    d = e_rdy ? memword(e_addr) : 16'(($urandom));
    imem_rdy  = e_rdy;
    imem_data = d;
    #1;
    chk("imem_req", {15'd0, imem_req}, {15'd0, e_req});
    if (e_req) chk("imem_addr", imem_addr, e_addr);
    @(posedge clk); #1;
    if (r) begin
      m_pc     = rp & 16'hFFFE;
      m_valid  = 1'b0;
      m_halted = 1'b0;
      if (e_req && !e_rdy) begin
        m_out = 1'b1; m_oaddr = e_addr; m_disc = 1'b1;
      end else begin
        m_out = 1'b0; m_disc = 1'b0;
      end
    end else begin
      if (m_valid && !s) m_valid = 1'b0;
      if (e_req && e_rdy) begin
        if (!m_disc) begin
          m_valid = 1'b1;
          m_instr = d;
          m_spc   = e_addr;
          m_pc    = e_addr + 16'd2;
          if (d[15:11] == HALT_OPC) m_halted = 1'b1;
        end
        m_out = 1'b0; m_disc = 1'b0;
      end else if (e_req) begin
        m_out = 1'b1; m_oaddr = e_addr;
      end
    end
    if (e_req && !e_rdy) m_wcnt++;
    $display("cyc stall=%0b redir=%0b rp=%h req=%0b addr=%h rdy=%0b | valid=%0b instr=%h pc_out=%h pc2=%h halted=%0b",
             s, r, rp, e_req, e_addr, e_rdy, valid, instr, pc_out, pc_plus2, halted);
    chk("valid", {15'd0, valid}, {15'd0, m_valid});
    chk("halted", {15'd0, halted}, {15'd0, m_halted});
    if (m_valid) begin
      chk("instr", instr, m_instr);
      chk("pc_out", pc_out, m_spc);
      chk("pc_plus2", pc_plus2, m_spc + 16'd2);
    end
  endtask

  initial begin
    logic found;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    imem_rdy = 1'b0; imem_data = 16'h0000;
    halt_addr = 16'hFFFF;
    lat_fix = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Zero-wait stream.
    do_reset();
    lat_fix = 0;
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 16'h0000);

    // Wait states plus a 4-cycle stall holding address 0x0004.
    do_reset();
    lat_fix = 3;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cycle(1'b0, 1'b0, 16'h0000);
      if (m_valid && m_spc == 16'h0004) begin found = 1'b1; break; end
    end
    chk("tmo_slot4", {15'd0, found}, 16'd1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 16'h0000);

    // Redirect while the request to 0x0010 is waiting.
    do_reset();
    lat_fix = 3;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      logic r;
      r = m_out && (m_oaddr == 16'h0010) && !m_disc;
      cycle(1'b0, r, 16'h0201);
      if (r) begin found = 1'b1; break; end
    end
    chk("tmo_wait10", {15'd0, found}, 16'd1);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 16'h0000);

    // HALT word at 0x0008, then resume via redirect to 0x0020.
    do_reset();
    lat_fix = 0;
    halt_addr = 16'h0008;
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 16'h0000);
    cycle(1'b0, 1'b1, 16'h0020);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 16'h0000);
    halt_addr = 16'hFFFF;

    // PC wrap at 0xFFFE.
    cycle(1'b0, 1'b1, 16'hFFFE);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 16'h0000);

    // Reset while a request is waiting.
    lat_fix = 3;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, 16'h0000);
      if (m_out) begin found = 1'b1; break; end
    end
    chk("tmo_wait_rst", {15'd0, found}, 16'd1);
    do_reset();
    cycle(1'b0, 1'b0, 16'h0000);

    // Randomized traffic with stalls, redirects and occasional HALTs.
    do_reset();
    lat_fix = -1;
    halt_addr = 16'h0040;
    for (int i = 0; i < 800; i++) begin
      logic s, r;
      logic [15:0] rp;
      s  = ($urandom_range(0, 99) < 30);
      r  = ($urandom_range(0, 99) < 5);
      rp = 16'($urandom_range(0, 16'h007F));
      cycle(s, r, rp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
